// File: rtl/eda_scan_sequencer.sv
// Raster-scan seed sequencer: probes the visited-mark RAM and hands out the next unvisited pixel.
// Optional skip statistics (skip_cnt output) are enabled by defining EDA_SCAN_STATS_EN.
module eda_scan_sequencer #(
  parameter int I_WIDTH    = 8,
  parameter int J_WIDTH    = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [I_WIDTH-1:0]    cfg_last_row,
  input  logic [J_WIDTH-1:0]    cfg_last_col,
  input  logic                  advance,
  input  logic                  mark_valid,
  input  logic [ADDR_WIDTH-1:0] mark_addr,
  output logic                  vis_rd_en,
  output logic [ADDR_WIDTH-1:0] vis_rd_addr,
  input  logic                  vis_rd_data,
  output logic [I_WIDTH-1:0]    next_row,
  output logic [J_WIDTH-1:0]    next_col,
  output logic                  next_valid,
  output logic                  iterated_all,
`ifdef EDA_SCAN_STATS_EN
  output logic [ADDR_WIDTH:0]   skip_cnt,
`endif
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    WAIT,
    HOLD,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [I_WIDTH-1:0]    row_q, row_d;
  logic [J_WIDTH-1:0]    col_q, col_d;
  logic [I_WIDTH-1:0]    last_row_q, last_row_d;
  logic [J_WIDTH-1:0]    last_col_q, last_col_d;
  logic [I_WIDTH-1:0]    next_row_q, next_row_d;
  logic [J_WIDTH-1:0]    next_col_q, next_col_d;
  logic                  next_valid_q, next_valid_d;
  logic                  iterated_all_q, iterated_all_d;
  logic                  vis_rd_en_q, vis_rd_en_d;
  logic [ADDR_WIDTH-1:0] vis_rd_addr_q, vis_rd_addr_d;
  logic                  busy_q, busy_d;

  logic [ADDR_WIDTH-1:0] pos_addr;
  logic [ADDR_WIDTH-1:0] step_addr;
  logic [I_WIDTH-1:0]    step_row;
  logic [J_WIDTH-1:0]    step_col;
  logic                  at_last;
  logic                  mark_hit;
  logic                  wait_hit;

  // pos only moves on a step, so in HOLD it still equals the held seed address;
  // one comparator therefore serves both the in-flight probe and the held seed.
  always_comb begin
    pos_addr = {row_q, col_q};
    at_last  = (row_q == last_row_q) && (col_q == last_col_q);
    if (col_q == last_col_q) begin
      step_row = row_q + I_WIDTH'(1);
      step_col = '0;
    end else begin
      step_row = row_q;
      step_col = col_q + J_WIDTH'(1);
    end
    step_addr = {step_row, step_col};
    mark_hit  = mark_valid && (mark_addr == pos_addr);
    wait_hit  = vis_rd_data || mark_hit;
  end

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    last_row_d     = last_row_q;
    last_col_d     = last_col_q;
    next_row_d     = next_row_q;
    next_col_d     = next_col_q;
    next_valid_d   = next_valid_q;
    iterated_all_d = iterated_all_q;
    vis_rd_en_d    = 1'b0;
    vis_rd_addr_d  = vis_rd_addr_q;

    if (start) begin
      last_row_d     = cfg_last_row;
      last_col_d     = cfg_last_col;
      row_d          = '0;
      col_d          = '0;
      next_valid_d   = 1'b0;
      iterated_all_d = 1'b0;
      vis_rd_en_d    = 1'b1;
      vis_rd_addr_d  = '0;
      state_d        = PROBE;
    end else begin
      unique case (state_q)
        PROBE: state_d = WAIT;
        WAIT: begin
          if (!wait_hit) begin
            next_row_d   = row_q;
            next_col_d   = col_q;
            next_valid_d = 1'b1;
            state_d      = HOLD;
          end else if (at_last) begin
            iterated_all_d = 1'b1;
            state_d        = DONE;
          end else begin
            row_d         = step_row;
            col_d         = step_col;
            vis_rd_en_d   = 1'b1;
            vis_rd_addr_d = step_addr;
            state_d       = PROBE;
          end
        end
        HOLD: begin
          // Consumption and a snoop drop behave identically and never double-step.
          if (advance || mark_hit) begin
            next_valid_d = 1'b0;
            if (at_last) begin
              iterated_all_d = 1'b1;
              state_d        = DONE;
            end else begin
              row_d         = step_row;
              col_d         = step_col;
              vis_rd_en_d   = 1'b1;
              vis_rd_addr_d = step_addr;
              state_d       = PROBE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end

    busy_d = (state_d == PROBE) || (state_d == WAIT) || (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      last_row_q     <= '0;
      last_col_q     <= '0;
      next_row_q     <= '0;
      next_col_q     <= '0;
      next_valid_q   <= 1'b0;
      iterated_all_q <= 1'b0;
      vis_rd_en_q    <= 1'b0;
      vis_rd_addr_q  <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      last_row_q     <= last_row_d;
      last_col_q     <= last_col_d;
      next_row_q     <= next_row_d;
      next_col_q     <= next_col_d;
      next_valid_q   <= next_valid_d;
      iterated_all_q <= iterated_all_d;
      vis_rd_en_q    <= vis_rd_en_d;
      vis_rd_addr_q  <= vis_rd_addr_d;
      busy_q         <= busy_d;
    end
  end

  assign vis_rd_en    = vis_rd_en_q;
  assign vis_rd_addr  = vis_rd_addr_q;
  assign next_row     = next_row_q;
  assign next_col     = next_col_q;
  assign next_valid   = next_valid_q;
  assign iterated_all = iterated_all_q;
  assign busy         = busy_q;

`ifdef EDA_SCAN_STATS_EN
  logic [ADDR_WIDTH:0] skip_cnt_q, skip_cnt_d;
  logic                skip_inc;

  // A dropped held seed counts only when it was not consumed in the same cycle.
  always_comb begin
    skip_inc   = !start && (((state_q == WAIT) && wait_hit) ||
                            ((state_q == HOLD) && mark_hit && !advance));
    skip_cnt_d = skip_cnt_q;
    if (start) begin
      skip_cnt_d = '0;
    end else if (skip_inc && (skip_cnt_q != '1)) begin
      skip_cnt_d = skip_cnt_q + (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skip_cnt_q <= '0;
    end else begin
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign skip_cnt = skip_cnt_q;
`endif

endmodule
